ifu_pipelined: RTL and testbench

Parametrised instruction fetch unit that replaces the single-outstanding IFU in the frontend. It sits between BPU, ICache and IBuffer. It issues up to MAX_OUTSTANDING in-order ICache requests back to back, buffers returned fetch groups in an output FIFO, and discards responses made stale by a backend flush, so the pipeline never stalls on a redirect.

---
 rtl/ifu_pipelined_pkg.sv | 60 ++++++
 rtl/ifu_sync_fifo.sv | 52 +++++
 rtl/ifu_pipelined.sv | 138 +++++++++++++
 tb/tb_ifu_pipelined.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pipelined_pkg.sv
// Frontend fetch types shared by the pipelined IFU and its output FIFO.
// Global fetch geometry, per-request metadata and the slot/next-PC computation.
package ifu_pipelined_pkg;

    typedef struct packed {
        int unsigned plen;
        int unsigned vlen;
        int unsigned ilen;
        int unsigned instr_per_fetch;
    } cfg_t;

    localparam cfg_t EMPTY_CFG = '{plen: 32, vlen: 32, ilen: 32, instr_per_fetch: 4};

    localparam int PLEN            = int'(EMPTY_CFG.plen);
    localparam int VLEN            = int'(EMPTY_CFG.vlen);
    localparam int ILEN            = int'(EMPTY_CFG.ilen);
    localparam int INSTR_PER_FETCH = int'(EMPTY_CFG.instr_per_fetch);
    localparam int INSTR_BYTES     = ILEN / 8;
    localparam int FETCH_W         = INSTR_PER_FETCH * ILEN;
    localparam int SLOT_IDX_W      = INSTR_PER_FETCH > 1 ? $clog2(INSTR_PER_FETCH) : 1;

    typedef struct packed {
        logic [PLEN-1:0]       pc;
        logic                  pred_slot_valid;
        logic [SLOT_IDX_W-1:0] pred_slot_idx;
        logic [PLEN-1:0]       pred_target;
        logic                  stale;
    } fetch_meta_t;

    typedef struct packed {
        logic [PLEN-1:0]                 pc;
        logic [FETCH_W-1:0]              data;
        logic [INSTR_PER_FETCH-1:0]      slot_valid;
        logic [INSTR_PER_FETCH*PLEN-1:0] pred_npc;
    } fetch_group_t;

    // Slots after a predicted-taken slot are dead; the taken slot itself redirects.
    function automatic fetch_group_t build_group(input fetch_meta_t meta,
                                                 input logic [FETCH_W-1:0] data);
        fetch_group_t g;
        g.pc         = meta.pc;
        g.data       = data;
        g.slot_valid = '0;
        g.pred_npc   = '0;
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            if (meta.pred_slot_valid && i > int'(meta.pred_slot_idx)) begin
                g.slot_valid[i]            = 1'b0;
                g.pred_npc[i*PLEN +: PLEN] = '0;
            end else if (meta.pred_slot_valid && i == int'(meta.pred_slot_idx)) begin
                g.slot_valid[i]            = 1'b1;
                g.pred_npc[i*PLEN +: PLEN] = meta.pred_target;
            end else begin
                g.slot_valid[i]            = 1'b1;
                g.pred_npc[i*PLEN +: PLEN] = meta.pc + PLEN'(INSTR_BYTES * (i + 1));
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Synchronous FIFO with a synchronous clear and an occupancy count.
// The head entry is presented combinationally; push-when-full is prevented upstream.
module ifu_sync_fifo #(
    parameter type T        = logic,
    parameter int  DEPTH    = 4,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/ifu_pipelined.sv
// Pipelined instruction fetch unit: in-order, credit-limited ICache requests with
// stale-marking on backend redirect and a registered output FIFO to the IBuffer.
module ifu_pipelined
    import ifu_pipelined_pkg::*;
#(
    parameter cfg_t            Cfg             = EMPTY_CFG,
    parameter logic [PLEN-1:0] RESET_PC        = PLEN'('h8000_0000),
    parameter int              MAX_OUTSTANDING = 4,
    parameter int              OUT_DEPTH       = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    output logic [Cfg.plen-1:0]                          ifu2bpu_pc_o,
    input  logic [Cfg.plen-1:0]                          bpu2ifu_predicted_pc_i,
    input  logic                                         bpu2ifu_pred_slot_valid_i,
    input  logic [SLOT_IDX_W-1:0]                        bpu2ifu_pred_slot_idx_i,
    input  logic [Cfg.plen-1:0]                          bpu2ifu_pred_target_i,
    output logic                                         icache_req_valid_o,
    input  logic                                         icache_req_ready_i,
    output logic [Cfg.vlen-1:0]                          icache_req_addr_o,
    input  logic                                         icache_rsp_valid_i,
    input  logic [Cfg.instr_per_fetch*Cfg.ilen-1:0]      icache_rsp_data_i,
    output logic                                         flush_icache_o,
    output logic                                         ibuf_valid_o,
    input  logic                                         ibuf_ready_i,
    output logic [Cfg.plen-1:0]                          ibuf_pc_o,
    output logic [Cfg.instr_per_fetch*Cfg.ilen-1:0]      ibuf_data_o,
    output logic [Cfg.instr_per_fetch-1:0]               ibuf_slot_valid_o,
    output logic [Cfg.instr_per_fetch*Cfg.plen-1:0]      ibuf_pred_npc_o,
    input  logic                                         flush_i,
    input  logic [Cfg.plen-1:0]                          redirect_pc_i
);

    localparam int PEND_PTR_W = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PEND_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int OUT_CNT_W  = $clog2(OUT_DEPTH + 1);

    logic [PLEN-1:0]       pc_reg;
    fetch_meta_t           pend_q [MAX_OUTSTANDING];
    logic [PEND_PTR_W-1:0] pend_wr_ptr;
    logic [PEND_PTR_W-1:0] pend_rd_ptr;
    logic [PEND_CNT_W-1:0] pend_cnt;
    logic [OUT_CNT_W-1:0]  out_cnt;
    logic                  out_empty;

    logic                  can_issue;
    logic                  req_fire;
    logic                  out_push;
    logic                  out_pop;
    fetch_meta_t           new_meta;
    fetch_meta_t           head_meta;
    fetch_group_t          rsp_group;
    fetch_group_t          head_group;

    function automatic logic [PEND_PTR_W-1:0] pend_inc(input logic [PEND_PTR_W-1:0] ptr);
        return (ptr == PEND_PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        can_issue = (int'(pend_cnt) < MAX_OUTSTANDING) &&
                    (int'(pend_cnt) + int'(out_cnt) < OUT_DEPTH);
        new_meta                 = '0;
        new_meta.pc              = pc_reg;
        new_meta.pred_slot_valid = bpu2ifu_pred_slot_valid_i;
        new_meta.pred_slot_idx   = bpu2ifu_pred_slot_idx_i;
        new_meta.pred_target     = bpu2ifu_pred_target_i;
        head_meta = pend_q[pend_rd_ptr];
        rsp_group = build_group(head_meta, icache_rsp_data_i);
    end

    assign icache_req_valid_o = !rst && !flush_i && can_issue;
    assign req_fire           = icache_req_valid_o && icache_req_ready_i;
    // A response arriving with a flush belongs to the old path even if not yet marked.
    assign out_push           = icache_rsp_valid_i && !head_meta.stale && !flush_i;
    assign out_pop            = ibuf_valid_o && ibuf_ready_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else if (flush_i) begin
            pc_reg <= redirect_pc_i;
        end else if (req_fire) begin
            pc_reg <= bpu2ifu_predicted_pc_i;
        end
    end

    // Stale entries keep their slot: ICache still owes one response per accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_wr_ptr <= '0;
            pend_rd_ptr <= '0;
            pend_cnt    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                pend_q[i].stale <= 1'b0;
            end
        end else begin
            if (req_fire) begin
                pend_q[pend_wr_ptr] <= new_meta;
                pend_wr_ptr         <= pend_inc(pend_wr_ptr);
            end
            if (icache_rsp_valid_i) begin
                pend_rd_ptr <= pend_inc(pend_rd_ptr);
            end
            pend_cnt <= pend_cnt + PEND_CNT_W'(req_fire) - PEND_CNT_W'(icache_rsp_valid_i);
            if (flush_i) begin
                for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                    pend_q[i].stale <= 1'b1;
                end
            end
        end
    end

    ifu_sync_fifo #(
        .T     (fetch_group_t),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush_i),
        .push      (out_push),
        .push_data (rsp_group),
        .pop       (out_pop),
        .head      (head_group),
        .empty     (out_empty),
        .count     (out_cnt)
    );

    assign ifu2bpu_pc_o      = pc_reg;
    assign icache_req_addr_o = pc_reg;
    assign flush_icache_o    = flush_i;
    assign ibuf_valid_o      = !out_empty;
    assign ibuf_pc_o         = head_group.pc;
    assign ibuf_data_o       = head_group.data;
    assign ibuf_slot_valid_o = head_group.slot_valid;
    assign ibuf_pred_npc_o   = head_group.pred_npc;

endmodule

// File: tb/tb_ifu_pipelined.sv
// Self-checking bench for ifu_pipelined: ICache/BPU models plus a transaction-level
// scoreboard tracking accepted requests by redirect epoch and the groups owed to the IBuffer.
module tb_ifu_pipelined;
    import ifu_pipelined_pkg::*;

    localparam int MAX_OUT   = 4;
    localparam int OUT_DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic                       clk;
    logic                       rst;
    logic [PLEN-1:0]            ifu2bpu_pc_o;
    logic [PLEN-1:0]            bpu2ifu_predicted_pc_i;
    logic                       bpu2ifu_pred_slot_valid_i;
    logic [SLOT_IDX_W-1:0]      bpu2ifu_pred_slot_idx_i;
    logic [PLEN-1:0]            bpu2ifu_pred_target_i;
    logic                       icache_req_valid_o;
    logic                       icache_req_ready_i;
    logic [VLEN-1:0]            icache_req_addr_o;
    logic                       icache_rsp_valid_i;
    logic [FETCH_W-1:0]         icache_rsp_data_i;
    logic                       flush_icache_o;
    logic                       ibuf_valid_o;
    logic                       ibuf_ready_i;
    logic [PLEN-1:0]            ibuf_pc_o;
    logic [FETCH_W-1:0]         ibuf_data_o;
    logic [INSTR_PER_FETCH-1:0] ibuf_slot_valid_o;
    logic [INSTR_PER_FETCH*PLEN-1:0] ibuf_pred_npc_o;
    logic                       flush_i;
    logic [PLEN-1:0]            redirect_pc_i;

    ifu_pipelined #(
        .RESET_PC        (RST_PC),
        .MAX_OUTSTANDING (MAX_OUT),
        .OUT_DEPTH       (OUT_DEPTH)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .ifu2bpu_pc_o              (ifu2bpu_pc_o),
        .bpu2ifu_predicted_pc_i    (bpu2ifu_predicted_pc_i),
        .bpu2ifu_pred_slot_valid_i (bpu2ifu_pred_slot_valid_i),
        .bpu2ifu_pred_slot_idx_i   (bpu2ifu_pred_slot_idx_i),
        .bpu2ifu_pred_target_i     (bpu2ifu_pred_target_i),
        .icache_req_valid_o        (icache_req_valid_o),
        .icache_req_ready_i        (icache_req_ready_i),
        .icache_req_addr_o         (icache_req_addr_o),
        .icache_rsp_valid_i        (icache_rsp_valid_i),
        .icache_rsp_data_i         (icache_rsp_data_i),
        .flush_icache_o            (flush_icache_o),
        .ibuf_valid_o              (ibuf_valid_o),
        .ibuf_ready_i              (ibuf_ready_i),
        .ibuf_pc_o                 (ibuf_pc_o),
        .ibuf_data_o               (ibuf_data_o),
        .ibuf_slot_valid_o         (ibuf_slot_valid_o),
        .ibuf_pred_npc_o           (ibuf_pred_npc_o),
        .flush_i                   (flush_i),
        .redirect_pc_i             (redirect_pc_i)
    );

    typedef struct {
        logic [31:0]  pc;
        logic         tk;
        logic [1:0]   idx;
        logic [31:0]  tgt;
        logic [127:0] data;
        int           due;
        int           epoch;
    } req_t;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] data;
        logic [3:0]   sv;
        logic [127:0] npc;
    } grp_t;

    req_t        icq[$];
    grp_t        expq[$];
    grp_t        deliv_log[$];
    logic [31:0] fire_log[$];
    int          fire_cyc[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          epoch = 0;
    logic [31:0] exp_pc = RST_PC;

    logic        rsp_en;
    logic        lat_rand;
    int          lat_fixed;
    logic        tk_en;
    logic [1:0]  tk_idx;
    logic [31:0] tk_tgt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A fetch group as the IBuffer should see it, from the request's PC and prediction.
    function automatic grp_t expect_group(input req_t r);
        grp_t g;
        int   last;
        g.pc   = r.pc;
        g.data = r.data;
        g.sv   = '0;
        g.npc  = '0;
        last   = r.tk ? int'(r.idx) : 3;
        for (int i = 0; i <= last; i++) begin
            g.sv[i] = 1'b1;
            if (r.tk && i == last) g.npc[i*32 +: 32] = r.tgt;
            else                   g.npc[i*32 +: 32] = r.pc + 32'(4 * (i + 1));
        end
        return g;
    endfunction

    // One clock: drive models at negedge, check, record what fires at the next posedge.
    task automatic step();
        req_t r;
        grp_t e;
        grp_t g;
        logic rsp;
        logic fire;
        logic pop;
        logic exp_v;
        rsp = rsp_en && (icq.size() > 0) && (icq[0].due <= cyc);
        icache_rsp_valid_i = rsp;
        icache_rsp_data_i  = rsp ? icq[0].data : '0;
        if (tk_en) begin
            bpu2ifu_pred_slot_valid_i = 1'b1;
            bpu2ifu_pred_slot_idx_i   = tk_idx;
            bpu2ifu_pred_target_i     = tk_tgt;
            bpu2ifu_predicted_pc_i    = tk_tgt;
        end else begin
            bpu2ifu_pred_slot_valid_i = 1'b0;
            bpu2ifu_pred_slot_idx_i   = '0;
            bpu2ifu_pred_target_i     = '0;
            bpu2ifu_predicted_pc_i    = ifu2bpu_pc_o + 32'h10;
        end
        #1;
        exp_v = !rst && !flush_i && (icq.size() < MAX_OUT) &&
                (icq.size() + expq.size() < OUT_DEPTH);
        total++;
        if (icache_req_valid_o !== exp_v) begin
            bad++;
            $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, icache_req_valid_o, exp_v);
        end
        total++;
        if (ibuf_valid_o !== (expq.size() != 0)) begin
            bad++;
            $display("FAIL ibuf_valid cyc=%0d got=%b exp=%b", cyc, ibuf_valid_o, expq.size() != 0);
        end
        total++;
        if (flush_icache_o !== flush_i) begin
            bad++;
            $display("FAIL flush_icache cyc=%0d got=%b exp=%b", cyc, flush_icache_o, flush_i);
        end
        fire = icache_req_valid_o && icache_req_ready_i;
        pop  = ibuf_valid_o && ibuf_ready_i && !flush_i && !rst;
        if (fire) begin
            total++;
            if (icache_req_addr_o !== exp_pc) begin
                bad++;
                $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, icache_req_addr_o, exp_pc);
            end
            r.pc    = icache_req_addr_o;
            r.tk    = bpu2ifu_pred_slot_valid_i;
            r.idx   = bpu2ifu_pred_slot_idx_i;
            r.tgt   = bpu2ifu_pred_target_i;
            r.data  = {$urandom, $urandom, $urandom, $urandom};
            r.due   = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fixed);
            r.epoch = epoch;
            icq.push_back(r);
            fire_log.push_back(icache_req_addr_o);
            fire_cyc.push_back(cyc);
            exp_pc = bpu2ifu_predicted_pc_i;
        end
        if (pop && expq.size() > 0) begin
            e = expq.pop_front();
            g.pc   = ibuf_pc_o;
            g.data = ibuf_data_o;
            g.sv   = ibuf_slot_valid_o;
            g.npc  = ibuf_pred_npc_o;
            total++;
            if ({g.pc, g.data, g.sv, g.npc} !== {e.pc, e.data, e.sv, e.npc}) begin
                bad++;
                $display("FAIL ibuf_group cyc=%0d got pc=%h sv=%b npc=%h exp pc=%h sv=%b npc=%h",
                         cyc, g.pc, g.sv, g.npc, e.pc, e.sv, e.npc);
            end
            deliv_log.push_back(g);
        end
        if (rsp) begin
            r = icq.pop_front();
            if (r.epoch == epoch && !flush_i && !rst) expq.push_back(expect_group(r));
        end
        if (flush_i) begin
            epoch++;
            expq.delete();
            exp_pc = redirect_pc_i;
        end
        if (rst) begin
            icq.delete();
            expq.delete();
            epoch++;
            exp_pc = RST_PC;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        icache_req_ready_i = 1'b0;
        rsp_en = 1'b1;
        ibuf_ready_i = 1'b1;
        tk_en = 1'b0;
        flush_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (icq.size() == 0 && expq.size() == 0 && !ibuf_valid_o) begin
                done = 1'b1;
                break;
            end
            step();
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout got=%0d/%0d exp=0/0", icq.size(), expq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        icache_req_ready_i = 1'b1;
        rsp_en = 1'b0;
        ibuf_ready_i = 1'b1;
        step();
        step();
        total++;
        if (ifu2bpu_pc_o !== RST_PC) begin
            bad++;
            $display("FAIL reset_pc got=%h exp=%h", ifu2bpu_pc_o, RST_PC);
        end
        total++;
        if (icache_req_valid_o !== 1'b0 || ibuf_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_valids got=%b%b exp=00", icache_req_valid_o, ibuf_valid_o);
        end
        total++;
        if (int'(dut.pend_cnt) != 0 || int'(dut.out_cnt) != 0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0", dut.pend_cnt, dut.out_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        fire_log.delete();
        fire_cyc.delete();
        deliv_log.delete();
        lat_rand = 1'b0;
        lat_fixed = 2;
        rsp_en = 1'b1;
        icache_req_ready_i = 1'b1;
        ibuf_ready_i = 1'b1;
        repeat (12) step();
        total++;
        if (fire_log.size() < 3 || deliv_log.size() < 3) begin
            bad++;
            $display("FAIL free_run_count got=%0d/%0d exp>=3", fire_log.size(), deliv_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (fire_log[i] !== RST_PC + 32'(16 * i) || fire_cyc[i] != fire_cyc[0] + i) begin
                    bad++;
                    $display("FAIL free_run_req%0d got=%h@%0d exp=%h@%0d", i, fire_log[i],
                             fire_cyc[i], RST_PC + 32'(16 * i), fire_cyc[0] + i);
                end
                total++;
                if (deliv_log[i].pc !== RST_PC + 32'(16 * i)) begin
                    bad++;
                    $display("FAIL free_run_deliv%0d got=%h exp=%h", i, deliv_log[i].pc,
                             RST_PC + 32'(16 * i));
                end
            end
        end
    endtask

    task automatic test_taken();
        int          n;
        logic [31:0] taken_pc;
        logic        found;
        grp_t        g;
        deliv_log.delete();
        tk_idx = 2'd1;
        tk_tgt = 32'h8000_1000;
        tk_en = 1'b1;
        n = fire_log.size();
        for (int i = 0; i < 10; i++) begin
            step();
            if (fire_log.size() > n) break;
        end
        tk_en = 1'b0;
        taken_pc = fire_log[$];
        n = fire_log.size();
        for (int i = 0; i < 10; i++) begin
            step();
            if (fire_log.size() > n) break;
        end
        total++;
        if (fire_log.size() <= n || fire_log[$] !== 32'h8000_1000) begin
            bad++;
            $display("FAIL taken_next_req got=%h exp=80001000", fire_log[$]);
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            foreach (deliv_log[k]) begin
                if (!found && deliv_log[k].pc === taken_pc) begin
                    found = 1'b1;
                    g = deliv_log[k];
                end
            end
            if (!found) step();
        end
        total++;
        if (!found || g.sv !== 4'b0011 || g.npc[32 +: 32] !== 32'h8000_1000 || g.npc[127:64] !== '0) begin
            bad++;
            $display("FAIL taken_group got found=%b sv=%b npc=%h exp sv=0011 npc1=80001000",
                     found, g.sv, g.npc);
        end
    endtask

    task automatic test_credit();
        int n;
        drain();
        icache_req_ready_i = 1'b1;
        rsp_en = 1'b0;
        n = fire_log.size();
        repeat (8) step();
        total++;
        if (fire_log.size() - n != MAX_OUT || icache_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL credit_pend got=%0d valid=%b exp=%0d valid=0", fire_log.size() - n,
                     icache_req_valid_o, MAX_OUT);
        end
        rsp_en = 1'b1;
        n = fire_log.size();
        for (int i = 0; i < 10; i++) begin
            step();
            if (fire_log.size() > n) break;
        end
        total++;
        if (fire_log.size() <= n) begin
            bad++;
            $display("FAIL credit_resume got=0 exp=1");
        end
        ibuf_ready_i = 1'b0;
        repeat (16) step();
        total++;
        if (int'(dut.out_cnt) + int'(dut.pend_cnt) != OUT_DEPTH || icache_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL credit_out got=%0d+%0d valid=%b exp=%0d valid=0", dut.pend_cnt,
                     dut.out_cnt, icache_req_valid_o, OUT_DEPTH);
        end
        ibuf_ready_i = 1'b1;
    endtask

    task automatic test_flush();
        int n;
        drain();
        icache_req_ready_i = 1'b1;
        rsp_en = 1'b0;
        n = fire_log.size();
        repeat (3) step();
        total++;
        if (fire_log.size() - n != 3) begin
            bad++;
            $display("FAIL flush_setup got=%0d exp=3", fire_log.size() - n);
        end
        flush_i = 1'b1;
        redirect_pc_i = 32'h8000_2000;
        step();
        flush_i = 1'b0;
        n = fire_log.size();
        deliv_log.delete();
        step();
        total++;
        if (fire_log.size() != n + 1 || fire_log[$] !== 32'h8000_2000) begin
            bad++;
            $display("FAIL flush_redirect_req got=%h exp=80002000", fire_log[$]);
        end
        rsp_en = 1'b1;
        repeat (15) step();
        total++;
        if (deliv_log.size() == 0 || deliv_log[0].pc !== 32'h8000_2000) begin
            bad++;
            $display("FAIL flush_first_deliv got=%h exp=80002000",
                     deliv_log.size() > 0 ? deliv_log[0].pc : 32'h0);
        end
    endtask

    task automatic test_flush_coincide();
        int exp_pend;
        drain();
        lat_rand = 1'b0;
        lat_fixed = 2;
        ibuf_ready_i = 1'b0;
        icache_req_ready_i = 1'b1;
        step();
        icache_req_ready_i = 1'b0;
        for (int i = 0; i < 10 && expq.size() == 0; i++) step();
        rsp_en = 1'b0;
        icache_req_ready_i = 1'b1;
        step();
        icache_req_ready_i = 1'b0;
        repeat (3) step();
        total++;
        if (icq.size() != 1 || expq.size() != 1) begin
            bad++;
            $display("FAIL coincide_setup got=%0d/%0d exp=1/1", icq.size(), expq.size());
        end
        exp_pend = icq.size() - 1;
        flush_i = 1'b1;
        redirect_pc_i = 32'h8000_3000;
        rsp_en = 1'b1;
        ibuf_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        rsp_en = 1'b0;
        ibuf_ready_i = 1'b0;
        total++;
        if (ibuf_valid_o !== 1'b0 || int'(dut.pend_cnt) != exp_pend) begin
            bad++;
            $display("FAIL coincide_state got valid=%b pend=%0d exp valid=0 pend=%0d",
                     ibuf_valid_o, dut.pend_cnt, exp_pend);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drain();
        icache_req_ready_i = 1'b1;
        rsp_en = 1'b0;
        step();
        step();
        icache_req_ready_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (int'(dut.pend_cnt) != 0 || int'(dut.out_cnt) != 0 || ibuf_valid_o !== 1'b0 ||
            ifu2bpu_pc_o !== RST_PC) begin
            bad++;
            $display("FAIL reset_mid got pend=%0d out=%0d valid=%b pc=%h exp 0 0 0 %h",
                     dut.pend_cnt, dut.out_cnt, ibuf_valid_o, ifu2bpu_pc_o, RST_PC);
        end
        icache_req_ready_i = 1'b1;
        rsp_en = 1'b1;
        n = fire_log.size();
        step();
        total++;
        if (fire_log.size() != n + 1 || fire_log[$] !== RST_PC) begin
            bad++;
            $display("FAIL reset_mid_restart got=%h exp=%h", fire_log[$], RST_PC);
        end
        repeat (6) step();
    endtask

    task automatic test_random();
        int n;
        lat_rand = 1'b1;
        n = deliv_log.size();
        for (int i = 0; i < 400; i++) begin
            icache_req_ready_i = ($urandom_range(0, 3) != 0);
            ibuf_ready_i       = ($urandom_range(0, 2) != 0);
            rsp_en             = ($urandom_range(0, 4) != 0);
            flush_i            = ($urandom_range(0, 29) == 0);
            redirect_pc_i      = $urandom & 32'hFFFF_FFF0;
            tk_en              = ($urandom_range(0, 3) == 0);
            tk_idx             = 2'($urandom_range(0, 3));
            tk_tgt             = $urandom & 32'hFFFF_FFFC;
            step();
        end
        drain();
        total++;
        if (deliv_log.size() - n < 20) begin
            bad++;
            $display("FAIL random_progress got=%0d exp>=20", deliv_log.size() - n);
        end
    endtask

    initial begin
        rst = 1'b1;
        icache_req_ready_i = 1'b0;
        icache_rsp_valid_i = 1'b0;
        icache_rsp_data_i = '0;
        ibuf_ready_i = 1'b0;
        flush_i = 1'b0;
        redirect_pc_i = '0;
        bpu2ifu_predicted_pc_i = '0;
        bpu2ifu_pred_slot_valid_i = 1'b0;
        bpu2ifu_pred_slot_idx_i = '0;
        bpu2ifu_pred_target_i = '0;
        rsp_en = 1'b0;
        lat_rand = 1'b0;
        lat_fixed = 2;
        tk_en = 1'b0;
        tk_idx = '0;
        tk_tgt = '0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_taken();
        test_credit();
        test_flush();
        test_flush_coincide();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
